// File: rtl/digest_pkg.sv
// Shared definitions for the digest checker and its downstream consumers.
// The status codes are also used by the validity register's PASS check.
package digest_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_BUSY    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Word index width; a single-word digest still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digest_check_idle_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT-1 while still enabled.
module idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count idle cycles; clear has priority so an accept restarts the window.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/digest_check.sv
// Streams a hash core's digest word by word, compares it against an expected
// digest captured at start, and holds a 3-bit result code until the next run.
module digest_check
  import digest_pkg::*;
#(
  parameter int  WORD_W    = DEF_WORD_W,
  parameter int  NUM_WORDS = DEF_NUM_WORDS,
  parameter int  TIMEOUT   = 1024,
  localparam int IDX_W     = idx_width(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WORD_W*NUM_WORDS-1:0] exp_digest,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [2:0]                  status,
  output logic [IDX_W-1:0]            mismatch_idx,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state;
  logic [WORD_W-1:0] exp_words [NUM_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              mismatch_flag;

  logic accept;
  logic word_mismatch;
  logic final_word;
  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  assign accept        = in_valid && in_ready;
  assign word_mismatch = (in_data != exp_words[idx]);
  assign final_word    = in_last || (idx == LAST_IDX);

  // The idle window only runs while waiting for a word in COMPARE.
  assign timer_clear  = !in_ready || accept || start;
  assign timer_enable = in_ready && !in_valid;

  idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_enable),
    .expire(timer_expire)
  );

  // Control FSM: start (re)arms a comparison from any state, accepted words
  // are checked against the captured digest, and the run ends on the final
  // word, a length violation, or an idle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      status        <= ST_IDLE;
      in_ready      <= 1'b0;
      done          <= 1'b0;
      mismatch_idx  <= '0;
      idx           <= '0;
      mismatch_flag <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        exp_words[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          exp_words[i] <= exp_digest[i*WORD_W +: WORD_W];
        end
        idx           <= '0;
        mismatch_flag <= 1'b0;
        mismatch_idx  <= '0;
        status        <= ST_BUSY;
        in_ready      <= 1'b1;
        state         <= S_COMPARE;
      end else if (state == S_COMPARE) begin
        if (accept) begin
          if (word_mismatch && !mismatch_flag) begin
            mismatch_flag <= 1'b1;
            mismatch_idx  <= idx;
          end
          if (final_word) begin
            state    <= S_DONE;
            in_ready <= 1'b0;
            done     <= 1'b1;
            if (in_last && (idx == LAST_IDX)) begin
              status <= (mismatch_flag || word_mismatch) ? ST_FAIL : ST_PASS;
            end else begin
              status <= ST_ERROR;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end else if (timer_expire) begin
          state    <= S_DONE;
          in_ready <= 1'b0;
          done     <= 1'b1;
          status   <= ST_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_digest_check.sv
// Testbench for digest_check: two instances (A and B) share all inputs except
// in_data, so the downstream validity AND of their PASS results can be tested.
module tb_digest_check;
  import digest_pkg::*;

  localparam int W  = 32;
  localparam int NW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W*NW-1:0] exp_digest = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  in_data_b;
  logic          in_ready_a, in_ready_b, done_a, done_b;
  logic [2:0]    status_a, status_b, midx_a, midx_b;
  logic          validity;

  int            cur_word = -1;
  int            b_ovr_idx = -1;
  logic [W-1:0]  b_ovr_val = '0;
  int            assert_cnt = 0;
  int            fail_cnt = 0;
  int            done_cnt_a = 0;
  int            done_cnt_b = 0;
  logic [W-1:0]  exp_w [NW];

  assign in_data_b = (b_ovr_idx >= 0 && cur_word == b_ovr_idx) ? b_ovr_val : in_data;
  assign validity  = (status_a == ST_PASS) && (status_b == ST_PASS);

  digest_check #(.WORD_W(W), .NUM_WORDS(NW), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .start(start), .exp_digest(exp_digest),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_a), .status(status_a), .mismatch_idx(midx_a), .done(done_a)
  );

  digest_check #(.WORD_W(W), .NUM_WORDS(NW), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .start(start), .exp_digest(exp_digest),
    .in_valid(in_valid), .in_data(in_data_b), .in_last(in_last),
    .in_ready(in_ready_b), .status(status_b), .mismatch_idx(midx_b), .done(done_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count done pulses shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  // Hard stop if the bench ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: walk the word list by the digest rules and report the outcome.
  function automatic void model_run(input logic [W-1:0] w[$], input bit l[$],
                                    output logic [2:0] st, output logic [2:0] mi,
                                    output int n);
    bit bad = 1'b0;
    st = ST_BUSY;
    mi = '0;
    n  = w.size();
    for (int k = 0; k < w.size(); k++) begin
      if (!bad && w[k] != exp_w[k]) begin
        bad = 1'b1;
        mi  = 3'(k);
      end
      if (l[k] || k == NW - 1) begin
        n  = k + 1;
        st = (l[k] && k == NW - 1) ? (bad ? ST_FAIL : ST_PASS) : ST_ERROR;
        return;
      end
    end
  endfunction

  task automatic do_start();
    for (int i = 0; i < NW; i++) exp_digest[i*W +: W] = exp_w[i];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NW; i++) exp_digest[i*W +: W] = $urandom;
  endtask

  task automatic send_words(input logic [W-1:0] w[$], input bit l[$], input int n, input int gap);
    int waited;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        assert_cnt++;
        if (status_a !== ST_BUSY) begin fail_cnt++; $display("[TB] FAIL busy_mid_stream word %0d: got %0d expected %0d", k, status_a, ST_BUSY); end
      end
      for (int g = 0; g < gap; g++) @(negedge clk);
      in_valid = 1'b1; in_data = w[k]; in_last = l[k]; cur_word = k;
      waited = 0;
      while (in_ready_a !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
      if (in_ready_a !== 1'b1) begin
        assert_cnt++; fail_cnt++;
        $display("[TB] FAIL handshake word %0d: got in_ready %b expected 1 within 40 cycles", k, in_ready_a);
        in_valid = 1'b0; in_last = 1'b0; cur_word = -1;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; cur_word = -1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    assert_cnt++; if (status_a !== ST_IDLE) begin fail_cnt++; $display("[TB] FAIL reset_status: got %0d expected %0d", status_a, ST_IDLE); end
    assert_cnt++; if (in_ready_a !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready_a); end
    assert_cnt++; if (done_a !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_done: got %b expected 0", done_a); end
    assert_cnt++; if (midx_a !== 3'd0) begin fail_cnt++; $display("[TB] FAIL reset_mismatch_idx: got %0d expected 0", midx_a); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass();
    logic [W-1:0] w[$]; bit l[$]; logic [2:0] st, mi; int n, d0;
    for (int i = 0; i < NW; i++) begin exp_w[i] = W'(i + 1); w.push_back(W'(i + 1)); l.push_back(i == NW - 1); end
    model_run(w, l, st, mi, n);
    d0 = done_cnt_a;
    do_start();
    assert_cnt++; if (status_a !== ST_BUSY) begin fail_cnt++; $display("[TB] FAIL pass_busy_after_start: got %0d expected %0d", status_a, ST_BUSY); end
    assert_cnt++; if (in_ready_b !== 1'b1) begin fail_cnt++; $display("[TB] FAIL pass_in_ready_b: got %b expected 1", in_ready_b); end
    send_words(w, l, n, 0);
    assert_cnt++; if (done_a !== 1'b1) begin fail_cnt++; $display("[TB] FAIL pass_done: got %b expected 1", done_a); end
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL pass_status: got %0d expected %0d", status_a, st); end
    assert_cnt++; if (midx_a !== mi) begin fail_cnt++; $display("[TB] FAIL pass_mismatch_idx: got %0d expected %0d", midx_a, mi); end
    assert_cnt++; if (validity !== (st == ST_PASS)) begin fail_cnt++; $display("[TB] FAIL pass_validity: got %b expected %b", validity, st == ST_PASS); end
    @(negedge clk);
    assert_cnt++; if (done_a !== 1'b0) begin fail_cnt++; $display("[TB] FAIL pass_done_one_cycle: got %b expected 0", done_a); end
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL pass_status_held: got %0d expected %0d", status_a, st); end
    assert_cnt++; if (in_ready_a !== 1'b0) begin fail_cnt++; $display("[TB] FAIL pass_in_ready_after: got %b expected 0", in_ready_a); end
    assert_cnt++; if (done_cnt_a - d0 !== 1) begin fail_cnt++; $display("[TB] FAIL pass_done_count: got %0d expected 1", done_cnt_a - d0); end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] w[$], wb[$]; bit l[$]; logic [2:0] st, mi, stb, mib; int n, nb;
    for (int i = 0; i < NW; i++) begin exp_w[i] = W'(i + 1); w.push_back(W'(i + 1)); l.push_back(i == NW - 1); end
    w[5] = 32'hDEADBEEF;
    wb = w; wb[5] = exp_w[5];
    b_ovr_idx = 5; b_ovr_val = exp_w[5];
    model_run(w, l, st, mi, n);
    model_run(wb, l, stb, mib, nb);
    do_start();
    send_words(w, l, n, 0);
    b_ovr_idx = -1;
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL mismatch_status_a: got %0d expected %0d", status_a, st); end
    assert_cnt++; if (midx_a !== mi) begin fail_cnt++; $display("[TB] FAIL mismatch_idx_a: got %0d expected %0d", midx_a, mi); end
    assert_cnt++; if (status_b !== stb) begin fail_cnt++; $display("[TB] FAIL mismatch_status_b: got %0d expected %0d", status_b, stb); end
    assert_cnt++; if (midx_b !== mib) begin fail_cnt++; $display("[TB] FAIL mismatch_idx_b: got %0d expected %0d", midx_b, mib); end
    assert_cnt++; if (validity !== (st == ST_PASS && stb == ST_PASS)) begin fail_cnt++; $display("[TB] FAIL mismatch_validity: got %b expected %b", validity, st == ST_PASS && stb == ST_PASS); end
  endtask

  task automatic test_short_long();
    logic [W-1:0] w[$]; bit l[$]; logic [2:0] st, mi; int n, d0;
    for (int i = 0; i < NW; i++) begin exp_w[i] = $urandom; w.push_back(exp_w[i]); l.push_back(i == 3); end
    model_run(w, l, st, mi, n);
    do_start();
    send_words(w, l, n, 0);
    assert_cnt++; if (done_a !== 1'b1) begin fail_cnt++; $display("[TB] FAIL short_done: got %b expected 1", done_a); end
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL short_status: got %0d expected %0d", status_a, st); end
    for (int i = 0; i < NW; i++) l[i] = 1'b0;
    model_run(w, l, st, mi, n);
    do_start();
    send_words(w, l, n, 0);
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL long_status: got %0d expected %0d", status_a, st); end
    d0 = done_cnt_a;
    in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    assert_cnt++; if (in_ready_a !== 1'b0) begin fail_cnt++; $display("[TB] FAIL long_in_ready_after: got %b expected 0", in_ready_a); end
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL long_status_held: got %0d expected %0d", status_a, st); end
    assert_cnt++; if (done_cnt_a !== d0) begin fail_cnt++; $display("[TB] FAIL long_no_extra_done: got %0d expected %0d", done_cnt_a, d0); end
  endtask

  task automatic test_timeout();
    int early;
    for (int i = 0; i < NW; i++) exp_w[i] = $urandom;
    do_start();
    early = 0;
    for (int c = 1; c < TO; c++) begin
      @(negedge clk);
      if (done_a === 1'b1 || status_a !== ST_BUSY) early++;
    end
    assert_cnt++; if (early !== 0) begin fail_cnt++; $display("[TB] FAIL timeout_early: got %0d early cycles expected 0", early); end
    @(negedge clk);
    assert_cnt++; if (done_a !== 1'b1) begin fail_cnt++; $display("[TB] FAIL timeout_done: got %b expected 1", done_a); end
    assert_cnt++; if (status_a !== ST_TIMEOUT) begin fail_cnt++; $display("[TB] FAIL timeout_status: got %0d expected %0d", status_a, ST_TIMEOUT); end
  endtask

  task automatic test_abort();
    logic [W-1:0] w[$]; bit l[$]; logic [2:0] st, mi; int n, d0;
    for (int i = 0; i < NW; i++) begin exp_w[i] = $urandom; w.push_back(exp_w[i]); l.push_back(1'b0); end
    d0 = done_cnt_a;
    do_start();
    send_words(w, l, 3, 0);
    w.delete(); l.delete();
    for (int i = 0; i < NW; i++) begin exp_w[i] = $urandom; w.push_back(exp_w[i]); l.push_back(i == NW - 1); end
    for (int i = 0; i < NW; i++) exp_digest[i*W +: W] = exp_w[i];
    start = 1'b1; in_valid = 1'b1; in_data = ~exp_w[0]; in_last = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    assert_cnt++; if (status_a !== ST_BUSY) begin fail_cnt++; $display("[TB] FAIL abort_busy: got %0d expected %0d", status_a, ST_BUSY); end
    assert_cnt++; if (done_cnt_a !== d0) begin fail_cnt++; $display("[TB] FAIL abort_no_done: got %0d expected %0d", done_cnt_a, d0); end
    model_run(w, l, st, mi, n);
    send_words(w, l, n, 0);
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL abort_status: got %0d expected %0d", status_a, st); end
    assert_cnt++; if (midx_a !== mi) begin fail_cnt++; $display("[TB] FAIL abort_mismatch_idx: got %0d expected %0d", midx_a, mi); end
    assert_cnt++; if (done_cnt_a - d0 !== 1) begin fail_cnt++; $display("[TB] FAIL abort_done_count: got %0d expected 1", done_cnt_a - d0); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w[$]; bit l[$]; int d0;
    for (int i = 0; i < NW; i++) begin exp_w[i] = $urandom; w.push_back(exp_w[i]); l.push_back(1'b0); end
    w[1] = ~exp_w[1];
    do_start();
    send_words(w, l, 3, 0);
    d0 = done_cnt_a;
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    assert_cnt++; if (status_a !== ST_IDLE) begin fail_cnt++; $display("[TB] FAIL reset_mid_status: got %0d expected %0d", status_a, ST_IDLE); end
    assert_cnt++; if (in_ready_a !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_mid_in_ready: got %b expected 0", in_ready_a); end
    assert_cnt++; if (midx_a !== 3'd0) begin fail_cnt++; $display("[TB] FAIL reset_mid_mismatch_idx: got %0d expected 0", midx_a); end
    reset = 1'b0; start = 1'b0;
    in_valid = 1'b1; in_data = exp_w[0]; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    assert_cnt++; if (status_a !== ST_IDLE) begin fail_cnt++; $display("[TB] FAIL idle_ignore_status: got %0d expected %0d", status_a, ST_IDLE); end
    assert_cnt++; if (done_cnt_a !== d0) begin fail_cnt++; $display("[TB] FAIL reset_mid_no_done: got %0d expected %0d", done_cnt_a, d0); end
  endtask

  task automatic test_gaps();
    logic [W-1:0] w[$]; bit l[$]; logic [2:0] st, mi; int n, d0;
    for (int i = 0; i < NW; i++) begin exp_w[i] = $urandom; w.push_back(exp_w[i]); l.push_back(i == NW - 1); end
    model_run(w, l, st, mi, n);
    do_start();
    send_words(w, l, n, 2);
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL gaps_status: got %0d expected %0d", status_a, st); end
    d0 = done_cnt_a;
    in_valid = 1'b1; in_data = ~exp_w[0]; in_last = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL done_ignore_status: got %0d expected %0d", status_a, st); end
    assert_cnt++; if (done_cnt_a !== d0) begin fail_cnt++; $display("[TB] FAIL done_ignore_done: got %0d expected %0d", done_cnt_a, d0); end
  endtask

  task automatic test_random();
    logic [W-1:0] w[$]; bit l[$]; logic [2:0] st, mi; int n, d0, lastpos, gap;
    logic [W-1:0] word;
    for (int it = 0; it < 25; it++) begin
      w.delete(); l.delete();
      lastpos = $urandom_range(0, 9);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < NW; i++) begin
        exp_w[i] = $urandom;
        word = exp_w[i];
        if ($urandom_range(0, 3) == 0) word = word ^ (32'd1 << $urandom_range(0, 31));
        w.push_back(word);
        l.push_back(i == lastpos);
      end
      model_run(w, l, st, mi, n);
      d0 = done_cnt_a;
      do_start();
      send_words(w, l, n, gap);
      assert_cnt++; if (status_a !== st) begin fail_cnt++; $display("[TB] FAIL random_status it %0d: got %0d expected %0d", it, status_a, st); end
      assert_cnt++; if (midx_a !== mi) begin fail_cnt++; $display("[TB] FAIL random_mismatch_idx it %0d: got %0d expected %0d", it, midx_a, mi); end
      assert_cnt++; if (status_b !== st) begin fail_cnt++; $display("[TB] FAIL random_status_b it %0d: got %0d expected %0d", it, status_b, st); end
      @(negedge clk);
      assert_cnt++; if (done_cnt_a - d0 !== 1) begin fail_cnt++; $display("[TB] FAIL random_done_count it %0d: got %0d expected 1", it, done_cnt_a - d0); end
    end
  endtask

  initial begin
    $display("[TB] digest_check bench starting");
    test_reset();
    test_pass();
    test_mismatch();
    test_pass();
    test_short_long();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
